// File: rtl/counter_pkg.sv
// counter_pkg: shared direction constants and load clamp for counter_nbit and related blocks.
// COUNTER_NBIT_SAT_EN is undefined by default, so counters wrap and have no sat port.
package counter_pkg;
    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;
    function automatic logic [31:0] clamp_to_mod(input logic [31:0] v, input logic [31:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction
endpackage

// File: rtl/counter_nbit_next.sv
// counter_nbit_next: combinational next-count and wrap-event decode for a modulo up/down counter.
module counter_nbit_next
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter longint unsigned MODULO = 64'(1) << WIDTH
) (
    input  logic [WIDTH-1:0] i_counter,
    input  logic             i_up,
    input  logic             i_sat,
    output logic [WIDTH-1:0] o_next,
    output logic             o_wrap_evt
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);
    logic w_edge;
    // compare against MAX explicitly so non-power-of-two moduli wrap correctly
    assign w_edge     = (i_up == CNT_UP) ? (i_counter == MAX) : (i_counter == '0);
    assign o_wrap_evt = w_edge & !i_sat;
    assign o_next     = w_edge ? (i_sat ? i_counter : ((i_up == CNT_UP) ? '0 : MAX))
                               : ((i_up == CNT_UP) ? i_counter + 1'b1 : i_counter - 1'b1);
endmodule

// File: rtl/counter_nbit.sv
// counter_nbit: modulo up/down counter with load, cascadable tc and sticky wrap flag.
// Define COUNTER_NBIT_SAT_EN to add the sat port (saturate instead of wrap).
module counter_nbit
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter longint unsigned MODULO = 64'(1) << WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_wrap,
`ifdef COUNTER_NBIT_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);
    logic [WIDTH-1:0] r_counter;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load;
    logic             w_wrap_evt;
    logic             w_sat;
`ifdef COUNTER_NBIT_SAT_EN
    assign w_sat = sat;
`else
    assign w_sat = 1'b0;
`endif
    assign w_load = WIDTH'(clamp_to_mod(32'(load_val), 32'(MAX)));
    counter_nbit_next #(.WIDTH(WIDTH), .MODULO(MODULO)) u_next (
        .i_counter (r_counter),
        .i_up      (up),
        .i_sat     (w_sat),
        .o_next    (w_next),
        .o_wrap_evt(w_wrap_evt)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_counter <= '0;
            r_wrap    <= 1'b0;
        end else begin
            if (load)
                r_counter <= w_load;
            else if (en)
                r_counter <= w_next;
            r_wrap <= (r_wrap & !clr_wrap) | (en & !load & w_wrap_evt);
        end
    end
    assign counter = r_counter;
    assign wrap    = r_wrap;
    assign tc      = en & !load & ((up == CNT_DN) ? (r_counter == '0) : (r_counter == MAX));
endmodule

// File: tb/tb_counter_nbit.sv
// tb_counter_nbit: directed self-checking bench for counter_nbit with WIDTH=3, MODULO=6.
module tb_counter_nbit;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, up = 1'b1, load = 1'b0, clr_wrap = 1'b0, sat = 1'b0;
    logic [2:0] load_val = '0;
    logic [2:0] counter;
    logic       tc, wrap;
    logic [2:0] c0_cnt, c1_cnt;
    logic       c0_tc, c1_tc, c0_wrap, c1_wrap;
    logic       c_en0 = 1'b1;
    int         n_checks = 0;
    int         n_errors = 0;
    int         exp_seq [7] = '{1, 2, 3, 4, 5, 0, 1};
    int         exp_wrp [7] = '{0, 0, 0, 0, 0, 1, 1};

    always #5 clk = ~clk;

    counter_nbit #(.WIDTH(3), .MODULO(6)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_wrap(clr_wrap),
`ifdef COUNTER_NBIT_SAT_EN
        .sat(sat),
`endif
        .counter(counter), .tc(tc), .wrap(wrap)
    );
    counter_nbit #(.WIDTH(3), .MODULO(6)) u_c0 (
        .clk(clk), .rst(rst), .en(c_en0), .up(1'b1), .load(1'b0), .load_val(3'd0),
        .clr_wrap(1'b0),
`ifdef COUNTER_NBIT_SAT_EN
        .sat(1'b0),
`endif
        .counter(c0_cnt), .tc(c0_tc), .wrap(c0_wrap)
    );
    counter_nbit #(.WIDTH(3), .MODULO(6)) u_c1 (
        .clk(clk), .rst(rst), .en(c0_tc), .up(1'b1), .load(1'b0), .load_val(3'd0),
        .clr_wrap(1'b0),
`ifdef COUNTER_NBIT_SAT_EN
        .sat(1'b0),
`endif
        .counter(c1_cnt), .tc(c1_tc), .wrap(c1_wrap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        en = 1'b1; up = 1'b0;
        #12;
        check("rst_counter", 32'(counter), 0);
        check("rst_wrap", 32'(wrap), 0);
        check("rst_tc_down", 32'(tc), 1);
        up = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        tick(4);
        check("pre_rst_count", 32'(counter), 4);
        #2 rst = 1'b0;
        #1;
        check("async_rst_counter", 32'(counter), 0);
        check("async_rst_wrap", 32'(wrap), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            check($sformatf("up_seq%0d", i), 32'(counter), 32'(exp_seq[i]));
            check($sformatf("up_wrap%0d", i), 32'(wrap), 32'(exp_wrp[i]));
        end
        up = 1'b0;
        tick(1);
        check("down_to0", 32'(counter), 0);
        check("down_tc_at0", 32'(tc), 1);
        tick(1);
        check("down_wrap_to5", 32'(counter), 5);
        check("down_wrap_flag", 32'(wrap), 1);
        en = 1'b0; clr_wrap = 1'b1;
        tick(1);
        check("clr_wrap", 32'(wrap), 0);
        check("clr_hold", 32'(counter), 5);
        clr_wrap = 1'b0; en = 1'b1;
        tick(5);
        check("down_reach0", 32'(counter), 0);
        clr_wrap = 1'b1;
        tick(1);
        check("set_wins_wrap", 32'(wrap), 1);
        check("set_wins_cnt", 32'(counter), 5);
        clr_wrap = 1'b0;
        up = 1'b1; load = 1'b1; load_val = 3'd3;
        #1;
        check("tc_masked_load", 32'(tc), 0);
        tick(1);
        check("load3", 32'(counter), 3);
        check("load_wrap_kept", 32'(wrap), 1);
        load = 1'b0; en = 1'b0; clr_wrap = 1'b1;
        tick(1);
        clr_wrap = 1'b0; en = 1'b1; load = 1'b1; load_val = 3'd7;
        tick(1);
        check("load_clamp", 32'(counter), 5);
        check("load_no_wrap", 32'(wrap), 0);
        load = 1'b0; en = 1'b0; up = 1'b1;
        #1;
        check("hold_tc0", 32'(tc), 0);
        tick(1);
        check("hold_cnt", 32'(counter), 5);
        en = 1'b1;
        #1;
        check("tc_immediate", 32'(tc), 1);
        tick(1);
        check("tc_next_wrap", 32'(counter), 0);
        check("tc_next_wrapflag", 32'(wrap), 1);
`ifdef COUNTER_NBIT_SAT_EN
        en = 1'b0; clr_wrap = 1'b1;
        tick(1);
        clr_wrap = 1'b0; load = 1'b1; load_val = 3'd4;
        tick(1);
        load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check($sformatf("sat_up%0d", i), 32'(counter), 5);
            check($sformatf("sat_up_wrap%0d", i), 32'(wrap), 0);
            check($sformatf("sat_up_tc%0d", i), 32'(tc), 1);
        end
        en = 1'b0; load = 1'b1; load_val = 3'd1;
        tick(1);
        load = 1'b0; en = 1'b1; up = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            check($sformatf("sat_dn%0d", i), 32'(counter), 0);
        end
        check("sat_dn_wrap", 32'(wrap), 0);
        sat = 1'b0;
`endif
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick(5);
        check("casc_c0_5", 32'(c0_cnt), 5);
        check("casc_c1_0", 32'(c1_cnt), 0);
        check("casc_tc0", 32'(c0_tc), 1);
        tick(1);
        check("casc_c0_wrap", 32'(c0_cnt), 0);
        check("casc_c1_1", 32'(c1_cnt), 1);
        tick(30);
        check("casc36_c0", 32'(c0_cnt), 0);
        check("casc36_c1", 32'(c1_cnt), 0);
        check("casc36_c1_wrap", 32'(c1_wrap), 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/counter_nbit.md
# counter_nbit

Parametrised synchronous up/down counter. It is the next generation of the 2-bit up counter, with configurable width and modulus, count enable, direction control, parallel load, a cascadable terminal-count output and a sticky wrap flag. It is a general building block for timers, address generators and cascaded prescalers.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range 1–32.
- `MODULO`, default 2**WIDTH: count range is 0..MODULO-1; legal range 2..2**WIDTH.
- `clk`  input  1: clock; all state updates on the rising edge.
- `rst`  input  1: reset, asynchronous and active-low.
- `en`  input  1: count enable.
- `up`  input  1: direction; 1 counts up, 0 counts down.
- `load`  input  1: parallel load strobe.
- `load_val`  input  WIDTH: value applied on `load`.
- `clr_wrap`  input  1: clears the sticky `wrap` flag.
- `sat`  input  1: saturate instead of wrap. Present only with `COUNTER_NBIT_SAT_EN`.
- `counter`  output  WIDTH: current count; registered.
- `tc`  output  1: terminal count / carry-out; combinational.
- `wrap`  output  1: sticky flag, set when a wrap-around occurs; registered.

## Operation
- Update priority on each rising edge: `load` > `en` > hold.
- **Load:** `counter` <= `load_val`. If `load_val` ≥ MODULO, the value clamps to MODULO-1. `en` and `up` are ignored in that cycle, and a load never sets `wrap`.
- **Count up** (`en`=1, `up`=1):
  - below MODULO-1: `counter` <= `counter`+1;
  - at MODULO-1: `counter` <= 0 and `wrap` is set.
- **Count down** (`en`=1, `up`=0):
  - above 0: `counter` <= `counter`-1;
  - at 0: `counter` <= MODULO-1 and `wrap` is set.
- **Hold** (`en`=0 and `load`=0): `counter` is unchanged.
- **Terminal count:** `tc` = `en` & !`load` & (`up` ? `counter`==MODULO-1 : `counter`==0). Cascading rule: connect `tc` of stage N to `en` of stage N+1.
- **Wrap flag:** `wrap` <= (`wrap` & !`clr_wrap`) | wrap_event. If a set and a clear occur in the same cycle, set wins.
- **Width rule:** all arithmetic is WIDTH bits. Compare against MODULO-1 and never rely on natural overflow, so non-power-of-two moduli wrap correctly.
- **Direction change:** a change of `up` takes effect on the next enabled edge. There is no extra state and no penalty cycle.

## Timing
- Reset (`rst`=0): `counter`=0 and `wrap`=0 immediately, independent of `clk`. `tc` then follows its equation from the reset state, for example `tc`=1 if `en`=1 and `up`=0.
- Reset mid-count: the count is lost and restarts from 0. There is no pending state.
- Release of `rst` is assumed synchronous to `clk` by the integrator. The first update happens on the first rising edge with `rst`=1.
- Latency: `counter` and `wrap` reflect inputs one cycle after the sampling edge. `tc` has zero latency, since it is a combinational decode of the registered count and the live inputs.
- Throughput: one step per enabled cycle, with no stalls.

## Configuration
- Macro: `COUNTER_NBIT_SAT_EN`.
- **Defined:**
  - the `sat` port exists;
  - when `sat`=1, an up-count at MODULO-1 holds at MODULO-1, and a down-count at 0 holds at 0;
  - `wrap` is not set while saturating;
  - `tc` still asserts at the terminal value;
  - `sat` sampled as 0 gives normal wrapping behaviour.
- **Undefined:** no `sat` port; the counter always wraps.

## Structure
- Shared package/include `counter_pkg`:
  - direction constants (`CNT_UP`=1, `CNT_DN`=0);
  - the macro default comment;
  - a `clamp_to_mod` function shared by the load path.
- Sub-module `counter_nbit_next`: combinational. It takes `counter`, `up`, `sat` and MODULO and returns next_count and wrap_event. It is shared with future timer and prescaler blocks.
- Top level: the register stage, load/enable muxing and the `tc` decode.

## Test plan
All scenarios use WIDTH=3 and MODULO=6.
- **Reset:** assert `rst`=0 mid-count at `counter`=4 → `counter`=0 and `wrap`=0 before the next edge; hold `en`=1 and `up`=1 for 7 edges → sequence 1,2,3,4,5,0,1, with `wrap`=1 from the 0.
- **Down wrap:** `up`=0 from `counter`=1 → 0 (`tc`=1 while at 0), then 5; `clr_wrap` pulse → `wrap`=0. `clr_wrap` coincident with a wrap event → `wrap` stays 1.
- **Load:** `load`=1 with `load_val`=3 and `en`=1 → 3, no increment. `load_val`=7 → clamps to 5, and `wrap` is unchanged.
- **Hold/tc:** `en`=0 at `counter`=5 with `up`=1 → `counter` stays 5 and `tc`=0. Raise `en` → `tc`=1 immediately and the next edge gives 0.
- **Cascade:** two instances with stage-0 `tc` driving stage-1 `en` and `en0`=1 → stage 1 advances once per 6 clocks; after 36 clocks both stages read 0.
- **Saturate** (`COUNTER_NBIT_SAT_EN` defined, `sat`=1): up from 4 → 5,5,5 with `wrap`=0 and `tc`=1; down from 1 → 0,0.
